// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor datapath.
//   DW / AW      : data width and register-select width
//   REG_S0..T1   : register select encodings
//   seq_state_t  : states of the register-port sequencer
package proc_pkg;

    localparam int DW = 8;
    localparam int AW = 2;

    localparam logic [AW-1:0] REG_S0 = 2'b00;
    localparam logic [AW-1:0] REG_S1 = 2'b01;
    localparam logic [AW-1:0] REG_T0 = 2'b10;
    localparam logic [AW-1:0] REG_T1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ACT,
        ST_WR_HOLD,
        ST_RD_A,
        ST_RD_B
    } seq_state_t;

endpackage

// File: rtl/reg_port_seq.sv
// Owner of the single shared register-bank port. Turns operand-fetch
// requests into one or two back-to-back reads and writeback requests into
// glitch-free writes. Every register-bank control is a flop output because
// the bank is level-sensitive.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   fetch_valid/rs/rt/two   : operand-fetch request
//   wb_valid/rd/data        : writeback request
//   req_ready               : requests accepted when high (IDLE)
//   op_a, op_b, op_valid    : fetched operands + one-cycle valid pulse
//   wb_done                 : one-cycle pulse after a write completes
//   rb_wr, rb_sel, rb_data  : to register bank WR / rs / data
//   rb_val                  : from register bank regVal
module reg_port_seq #(
    parameter int DW = proc_pkg::DW,
    parameter int AW = proc_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic [AW-1:0] fetch_rs,
    input  logic [AW-1:0] fetch_rt,
    input  logic          fetch_two,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic          req_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_valid,
    output logic          wb_done,
    output logic          rb_wr,
    output logic [AW-1:0] rb_sel,
    output logic [DW-1:0] rb_data,
    input  logic [DW-1:0] rb_val
);
    import proc_pkg::*;

    seq_state_t    state, state_d;

    // Fetch accepted together with a write waits here until the write ends.
    logic          pend, pend_d;
    logic [AW-1:0] pend_rs, pend_rs_d;
    logic [AW-1:0] rt_q, rt_d;
    logic          two_q, two_d;

    logic          rb_wr_d;
    logic [AW-1:0] rb_sel_d;
    logic [DW-1:0] rb_data_d;
    logic [DW-1:0] op_a_d, op_b_d;
    logic          op_valid_d, wb_done_d;

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pend     <= 1'b0;
            pend_rs  <= '0;
            rt_q     <= '0;
            two_q    <= 1'b0;
            rb_wr    <= 1'b0;
            rb_sel   <= '0;
            rb_data  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            wb_done  <= 1'b0;
        end else begin
            state    <= state_d;
            pend     <= pend_d;
            pend_rs  <= pend_rs_d;
            rt_q     <= rt_d;
            two_q    <= two_d;
            rb_wr    <= rb_wr_d;
            rb_sel   <= rb_sel_d;
            rb_data  <= rb_data_d;
            op_a     <= op_a_d;
            op_b     <= op_b_d;
            op_valid <= op_valid_d;
            wb_done  <= wb_done_d;
        end
    end

    always_comb begin
        state_d    = state;
        pend_d     = pend;
        pend_rs_d  = pend_rs;
        rt_d       = rt_q;
        two_d      = two_q;
        rb_wr_d    = 1'b0;
        rb_sel_d   = rb_sel;
        rb_data_d  = rb_data;
        op_a_d     = op_a;
        op_b_d     = op_b;
        op_valid_d = 1'b0;
        wb_done_d  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (fetch_valid) begin
                    rt_d  = fetch_rt;
                    two_d = fetch_two;
                end
                if (wb_valid) begin
                    // Write goes first so a simultaneous fetch sees the new value.
                    rb_sel_d  = wb_rd;
                    rb_data_d = wb_data;
                    rb_wr_d   = 1'b1;
                    state_d   = ST_WR_ACT;
                    if (fetch_valid) begin
                        pend_d    = 1'b1;
                        pend_rs_d = fetch_rs;
                    end
                end else if (fetch_valid) begin
                    rb_sel_d = fetch_rs;
                    state_d  = ST_RD_A;
                end
            end
            ST_WR_ACT: begin
                // Drop WR with sel/data still stable.
                state_d = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                // Extra cycle so sel does not move while the bank latch closes.
                wb_done_d = 1'b1;
                if (pend) begin
                    rb_sel_d = pend_rs;
                    pend_d   = 1'b0;
                    state_d  = ST_RD_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_A: begin
                op_a_d = rb_val;
                if (two_q) begin
                    rb_sel_d = rt_q;
                    state_d  = ST_RD_B;
                end else begin
                    op_b_d     = '0;
                    op_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_RD_B: begin
                op_b_d     = rb_val;
                op_valid_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_port_seq.sv
module tb_reg_port_seq;
    import proc_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_valid;
    logic [AW-1:0] fetch_rs, fetch_rt;
    logic          fetch_two;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          req_ready;
    logic [DW-1:0] op_a, op_b;
    logic          op_valid, wb_done;
    logic          rb_wr;
    logic [AW-1:0] rb_sel;
    logic [DW-1:0] rb_data;
    logic [DW-1:0] rb_val;

    int checks = 0;
    int errors = 0;

    // Level-sensitive register bank model: transparent while WR is high.
    logic [DW-1:0] bank [4] = '{default: '0};
    always @(rb_wr, rb_sel, rb_data) if (rb_wr) bank[rb_sel] = rb_data;
    assign rb_val = bank[rb_sel];

    always #5 clk = ~clk;

    reg_port_seq dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_rs(fetch_rs), .fetch_rt(fetch_rt),
        .fetch_two(fetch_two),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .req_ready(req_ready), .op_a(op_a), .op_b(op_b),
        .op_valid(op_valid), .wb_done(wb_done),
        .rb_wr(rb_wr), .rb_sel(rb_sel), .rb_data(rb_data), .rb_val(rb_val)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain write; request presented while IDLE, accepted at E0.
    task automatic do_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        tick();                                   // E0
        wb_valid = 1'b0;
        chk("wr_rise", rb_wr, 1'b1);
        chk("wr_sel0", rb_sel, rd);
        chk("wr_busy", req_ready, 1'b0);
        tick();                                   // E1
        chk("wr_fall", rb_wr, 1'b0);
        chk("wr_sel1", rb_sel, rd);
        chk("wr_data1", rb_data, d);
        chk("wr_done_early", wb_done, 1'b0);
        tick();                                   // E2
        chk("wr_done", wb_done, 1'b1);
        chk("wr_ready", req_ready, 1'b1);
        tick();
        chk("wr_done_pulse", wb_done, 1'b0);
    endtask

    task automatic do_fetch(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic two,
                            input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        @(negedge clk);
        fetch_valid = 1'b1; fetch_rs = rs; fetch_rt = rt; fetch_two = two;
        tick();                                   // E0
        fetch_valid = 1'b0;
        chk("rd_busy", req_ready, 1'b0);
        chk("rd_noval0", op_valid, 1'b0);
        chk("rd_nowr", rb_wr, 1'b0);
        if (two) begin
            tick();                               // E1
            chk("rd_noval1", op_valid, 1'b0);
            chk("rd_nowr1", rb_wr, 1'b0);
        end
        tick();
        chk("rd_valid", op_valid, 1'b1);
        chk("rd_op_a", op_a, ea);
        chk("rd_op_b", op_b, eb);
        tick();
        chk("rd_pulse", op_valid, 1'b0);
        chk("rd_hold_a", op_a, ea);
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_rs = '0; fetch_rt = '0; fetch_two = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_wr", rb_wr, 1'b0);
        chk("rst_sel", rb_sel, '0);
        chk("rst_data", rb_data, '0);
        chk("rst_opa", op_a, '0);
        chk("rst_opb", op_b, '0);
        chk("rst_opv", op_valid, 1'b0);
        chk("rst_done", wb_done, 1'b0);

        // Two-operand fetch of s0/s1
        do_write(REG_S0, 8'h12);
        do_write(REG_S1, 8'h34);
        do_fetch(REG_S0, REG_S1, 1'b1, 8'h12, 8'h34);

        // Write t1, then read it back
        do_write(REG_T1, 8'hA5);
        do_fetch(REG_T1, REG_S0, 1'b0, 8'hA5, 8'h00);
        // rs == rt
        do_fetch(REG_T1, REG_T1, 1'b1, 8'hA5, 8'hA5);

        // Simultaneous write s0=7E and fetch s0,t0
        do_write(REG_T0, 8'h01);
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = REG_S0; wb_data = 8'h7E;
        fetch_valid = 1'b1; fetch_rs = REG_S0; fetch_rt = REG_T0; fetch_two = 1'b1;
        tick();                                   // E0
        wb_valid = 1'b0; fetch_valid = 1'b0;
        chk("sim_wr0", rb_wr, 1'b1);
        tick();                                   // E1
        chk("sim_wr1", rb_wr, 1'b0);
        chk("sim_done1", wb_done, 1'b0);
        tick();                                   // E2
        chk("sim_done2", wb_done, 1'b1);
        chk("sim_sel2", rb_sel, REG_S0);
        chk("sim_ready2", req_ready, 1'b0);
        tick();                                   // E3
        chk("sim_noval3", op_valid, 1'b0);
        chk("sim_done3", wb_done, 1'b0);
        chk("sim_nowr3", rb_wr, 1'b0);
        tick();                                   // E4
        chk("sim_val4", op_valid, 1'b1);
        chk("sim_op_a", op_a, 8'h7E);
        chk("sim_op_b", op_b, 8'h01);
        tick();
        chk("sim_pulse", op_valid, 1'b0);

        // Write s1=FF with a one-operand fetch of s1 held through the busy period
        begin
            int pulses = 0;
            int acc = -1;
            int vcyc = -1;
            logic rdy;
            @(negedge clk);
            wb_valid = 1'b1; wb_rd = REG_S1; wb_data = 8'hFF;
            tick();                               // write accepted
            wb_valid = 1'b0;
            fetch_valid = 1'b1; fetch_rs = REG_S1; fetch_rt = REG_T0; fetch_two = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                rdy = req_ready;
                tick();
                if (rdy && fetch_valid) begin
                    fetch_valid = 1'b0;
                    acc = i;
                end
                if (op_valid) begin
                    pulses++;
                    vcyc = i;
                    chk("held_op_a", op_a, 8'hFF);
                    chk("held_op_b", op_b, 8'h00);
                end
            end
            fetch_valid = 1'b0;
            chk("held_accept_cyc", acc, 2);
            chk("held_pulses", pulses, 1);
            chk("held_latency", vcyc, 3);
        end

        // Reset during WR_ACT
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = REG_T0; wb_data = 8'h55;
        tick();
        wb_valid = 1'b0;
        chk("rstmid_wr", rb_wr, 1'b1);
        reset = 1'b1;
        tick();
        chk("rstmid_wr_low", rb_wr, 1'b0);
        chk("rstmid_ready", req_ready, 1'b1);
        chk("rstmid_done", wb_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_done", wb_done, 1'b0);
            chk("rstmid_no_wr", rb_wr, 1'b0);
            chk("rstmid_idle", req_ready, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach end");
        $fatal(1);
    end

endmodule
